muacm_in_arb: RTL

MUACM_IN_ARB -- requirements
Module: muacm_in_arb

---
 rtl/muacm_in_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/muacm_in_arb.sv
// Two-source round-robin byte arbiter in front of the muacm IN pipe.
// Bounds each grant to MAX_BURST beats and requests a flush on packet end or source stall.
module muacm_in_arb #(
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned IDLE_TO   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s0_data,
   input  logic       s0_last,
   input  logic       s0_valid,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_last,
   input  logic       s1_valid,
   output logic       s1_ready,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_flush_now,
   output logic       m_flush_time,
   output logic [1:0] grant
);

   localparam int unsigned      CNT_W     = 8;
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(IDLE_TO);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             sel_q, sel_d;       // index of the granted source
   logic             rr_q, rr_d;         // source that wins on contention
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [1:0]       grant_q, grant_d;
   logic             flush_now_q, flush_now_d;
   logic             flush_time_q, flush_time_d;
   logic [1:0]       rst_sync_q;
   logic             rst_int_n;
   logic             hs;
   logic [CNT_W-1:0] stall_inc;

   // Reset asserts immediately, releases two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   // Pass-through from the granted source; nothing moves without a grant
   always_comb begin
      m_data   = 8'h00;
      m_last   = 1'b0;
      m_valid  = 1'b0;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      if (grant_q[0]) begin
         m_data   = s0_data;
         m_last   = s0_last;
         m_valid  = s0_valid;
         s0_ready = m_ready;
      end else if (grant_q[1]) begin
         m_data   = s1_data;
         m_last   = s1_last;
         m_valid  = s1_valid;
         s1_ready = m_ready;
      end
   end

   assign hs        = m_valid & m_ready;
   assign stall_inc = stall_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      stall_d = stall_q;
      case (state_q)
         ST_IDLE: begin
            if (s0_valid | s1_valid) begin
               state_d = ST_XFER;
               sel_d   = (s0_valid & s1_valid) ? rr_q : s1_valid;
               beat_d  = '0;
               stall_d = '0;
            end
         end
         ST_XFER: begin
            stall_d = m_valid ? '0 : stall_inc;
            if (hs) beat_d = beat_q + CNT_W'(1);
            // packet end outranks the burst limit on the same beat
            if (hs && m_last)                         state_d = ST_FLUSH;
            else if (hs && (beat_q == BEAT_LAST))     state_d = ST_IDLE;
            else if (!m_valid && (stall_inc == STALL_MAX)) state_d = ST_FLUSH;
            if (state_d != ST_XFER) rr_d = ~sel_q;
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      grant_d      = (state_d == ST_XFER) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
      flush_now_d  = (state_d == ST_FLUSH);
      flush_time_d = (state_d != ST_XFER);
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         rr_q         <= 1'b0;
         beat_q       <= '0;
         stall_q      <= '0;
         grant_q      <= 2'b00;
         flush_now_q  <= 1'b0;
         flush_time_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         rr_q         <= rr_d;
         beat_q       <= beat_d;
         stall_q      <= stall_d;
         grant_q      <= grant_d;
         flush_now_q  <= flush_now_d;
         flush_time_q <= flush_time_d;
      end
   end

   assign grant        = grant_q;
   assign m_flush_now  = flush_now_q;
   assign m_flush_time = flush_time_q;

endmodule
